// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit that sits at the ID/EX boundary.
// It keeps a shift-register scoreboard of in-flight register writes, including
// how many cycles each result still needs before it can be forwarded.
// For every source operand of the instruction in ID it picks a forwarding slot,
// or it requests a stall when the youngest matching writer is not ready yet.
module fwd_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int REG_W     = $clog2(NUM_REGS),
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1),
  parameter int LAT_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic                     issue_wen,
  input  logic [REG_W-1:0]         issue_dst,
  input  logic [LAT_W-1:0]         issue_lat,
  input  logic                     flush,
  input  logic [NUM_SRC*REG_W-1:0] src_reg,
  input  logic [NUM_SRC-1:0]       src_used,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic [15:0]              stall_count
);

  // Index 0 of each array is slot 1 (EX/MEM); index FWD_DEPTH-1 is the last
  // forwardable stage before the register file write.
  logic [FWD_DEPTH-1:0]            valid_q, valid_d;
  logic [FWD_DEPTH-1:0]            wen_q,   wen_d;
  logic [FWD_DEPTH-1:0][REG_W-1:0] dst_q,   dst_d;
  logic [FWD_DEPTH-1:0][LAT_W-1:0] rem_q,   rem_d;
  logic [15:0]                     stall_count_q, stall_count_d;

  logic [NUM_SRC-1:0] hazard;
  logic [REG_W-1:0]   cur_src;
  logic               matched;
  logic               accept;

  // Operand check: the youngest valid writer of each operand decides between
  // forwarding (result ready) and a hazard (result still in flight).
  always_comb begin
    fwd_sel = '0;
    hazard  = '0;
    cur_src = '0;
    matched = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cur_src = src_reg[i*REG_W +: REG_W];
      matched = 1'b0;
      if (src_used[i] && (cur_src != '0)) begin
        for (int k = 0; k < FWD_DEPTH; k++) begin
          if (!matched && valid_q[k] && wen_q[k] && (dst_q[k] == cur_src)) begin
            matched = 1'b1;
            if (rem_q[k] == '0) begin
              fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
            end else begin
              hazard[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // A flush or an empty ID stage never stalls; otherwise any operand hazard does.
  always_comb begin
    stall  = (|hazard) & issue_valid & ~flush;
    accept = issue_valid & ~stall & ~flush;
  end

  // Next slot state: slot 1 takes the accepted instruction or a bubble, older
  // slots shift down while their remaining latency counts towards zero.
  always_comb begin
    valid_d = '0;
    wen_d   = '0;
    dst_d   = '0;
    rem_d   = '0;
    valid_d[0] = accept;
    wen_d[0]   = accept & issue_wen & (issue_dst != '0);
    dst_d[0]   = accept ? issue_dst : '0;
    if (accept && (issue_lat != '0)) begin
      rem_d[0] = issue_lat - LAT_W'(1);
    end
    for (int k = 1; k < FWD_DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      wen_d[k]   = wen_q[k-1];
      dst_d[k]   = dst_q[k-1];
      rem_d[k]   = (rem_q[k-1] == '0) ? '0 : rem_q[k-1] - LAT_W'(1);
    end
  end

  // Stall performance counter, saturating at all ones.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Scoreboard and counter registers; reset empties every in-flight slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      wen_q         <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      wen_q         <= wen_d;
      dst_q         <= dst_d;
      rem_q         <= rem_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard.
// A default-depth instance covers forwarding, stalls, flush and reset; a
// deep instance (15 forwarding slots) produces long stall runs so that the
// saturating stall counter can be pushed past 16'hFFFF in a modest cycle count.
module tb_fwd_scoreboard;

  logic        clk;
  logic        rst_n;

  logic        issueValid;
  logic        issueWen;
  logic [4:0]  issueDst;
  logic [1:0]  issueLat;
  logic        flushIn;
  logic [9:0]  srcReg;
  logic [1:0]  srcUsed;
  logic [3:0]  fwdSel;
  logic        stallOut;
  logic [15:0] stallCount;

  logic        deepValid;
  logic        deepWen;
  logic [4:0]  deepDst;
  logic [3:0]  deepLat;
  logic        deepFlush;
  logic [9:0]  deepSrc;
  logic [1:0]  deepUsed;
  logic [7:0]  deepFwd;
  logic        deepStall;
  logic [15:0] deepCount;

  int assertCount = 0;
  int failCount   = 0;

  fwd_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issueValid),
    .issue_wen   (issueWen),
    .issue_dst   (issueDst),
    .issue_lat   (issueLat),
    .flush       (flushIn),
    .src_reg     (srcReg),
    .src_used    (srcUsed),
    .fwd_sel     (fwdSel),
    .stall       (stallOut),
    .stall_count (stallCount)
  );

  fwd_scoreboard #(.FWD_DEPTH(15)) deepDut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (deepValid),
    .issue_wen   (deepWen),
    .issue_dst   (deepDst),
    .issue_lat   (deepLat),
    .flush       (deepFlush),
    .src_reg     (deepSrc),
    .src_used    (deepUsed),
    .fwd_sel     (deepFwd),
    .stall       (deepStall),
    .stall_count (deepCount)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the ID-stage inputs of the default instance, then let them settle.
  task automatic applyStimulus(input logic v, input logic w, input logic [4:0] d,
                               input logic [1:0] l, input logic f,
                               input logic [4:0] s0, input logic [4:0] s1,
                               input logic [1:0] u);
    issueValid = v;
    issueWen   = w;
    issueDst   = d;
    issueLat   = l;
    flushIn    = f;
    srcReg     = {s1, s0};
    srcUsed    = u;
    #1;
  endtask

  // One comparison: counts it and reports a failure with observed/expected.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare all outputs of the default instance.
  task automatic checkAll(input string tag, input logic [3:0] expFwd,
                          input logic expStall, input logic [15:0] expCount);
    checkOutput({tag, ".fwd_sel"}, 16'(fwdSel), 16'(expFwd));
    checkOutput({tag, ".stall"}, 16'(stallOut), 16'(expStall));
    checkOutput({tag, ".stall_count"}, stallCount, expCount);
  endtask

  // Advance one clock and sample away from the edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Directed sequence; expected values are worked out by hand from the
  // scoreboard rules (rem = lat-1 on issue, one decrement per shift).
  initial begin
    rst_n     = 1'b0;
    deepValid = 1'b0;
    deepWen   = 1'b0;
    deepDst   = 5'd0;
    deepLat   = 4'd1;
    deepFlush = 1'b0;
    deepSrc   = 10'd0;
    deepUsed  = 2'b00;

    // Reset held: outputs quiet even with a valid instruction in ID.
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 5'd5, 5'd6, 2'b11);
    checkAll("rstHeld", 4'h0, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 5'd5, 5'd6, 2'b11);
    checkAll("postRst", 4'h0, 1'b0, 16'd0);
    step();

    // ALU write to r8, then read it through slot 1, slot 2, then regfile.
    applyStimulus(1'b1, 1'b1, 5'd8, 2'd1, 1'b0, 5'd0, 5'd0, 2'b00);
    checkOutput("aluIssue.stall", 16'(stallOut), 16'd0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 2'd1, 1'b0, 5'd8, 5'd0, 2'b01);
    checkAll("alu.t1", 4'h1, 1'b0, 16'd0);
    step();
    checkAll("alu.t2", 4'h2, 1'b0, 16'd0);
    step();
    checkAll("alu.t3", 4'h0, 1'b0, 16'd0);
    step();

    // Load to r9 (latency 2): one stall cycle, then forward from slot 2.
    applyStimulus(1'b1, 1'b1, 5'd9, 2'd2, 1'b0, 5'd0, 5'd0, 2'b00);
    step();
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 5'd9, 5'd0, 2'b01);
    checkAll("load.stall", 4'h0, 1'b1, 16'd0);
    step();
    checkAll("load.fwd", 4'h2, 1'b0, 16'd1);
    step();

    // Write to r0 is never forwarded.
    applyStimulus(1'b1, 1'b1, 5'd0, 2'd1, 1'b0, 5'd0, 5'd0, 2'b00);
    step();
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 5'd0, 5'd0, 2'b11);
    checkAll("r0", 4'h0, 1'b0, 16'd1);
    step();

    // Second operand forwarding, then an unused operand is ignored.
    applyStimulus(1'b1, 1'b1, 5'd12, 2'd1, 1'b0, 5'd0, 5'd0, 2'b00);
    step();
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 5'd3, 5'd12, 2'b11);
    checkAll("src1", 4'h4, 1'b0, 16'd1);
    step();
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 5'd12, 5'd12, 2'b00);
    checkAll("unused", 4'h0, 1'b0, 16'd1);
    step();

    // Latency 0 behaves as latency 1.
    applyStimulus(1'b1, 1'b1, 5'd13, 2'd0, 1'b0, 5'd0, 5'd0, 2'b00);
    step();
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 5'd13, 5'd0, 2'b01);
    checkAll("lat0", 4'h1, 1'b0, 16'd1);
    step();

    // Two writers of r4: the younger, not-ready one forces a stall.
    applyStimulus(1'b1, 1'b1, 5'd4, 2'd1, 1'b0, 5'd0, 5'd0, 2'b00);
    step();
    applyStimulus(1'b1, 1'b1, 5'd4, 2'd2, 1'b0, 5'd0, 5'd0, 2'b00);
    step();
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 5'd4, 5'd0, 2'b01);
    checkAll("young.stall", 4'h0, 1'b1, 16'd1);
    step();
    checkAll("young.fwd", 4'h2, 1'b0, 16'd2);
    step();

    // Flush overrides a pending load hazard and does not count.
    applyStimulus(1'b1, 1'b1, 5'd10, 2'd2, 1'b0, 5'd0, 5'd0, 2'b00);
    step();
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b1, 5'd10, 5'd0, 2'b01);
    checkAll("flush", 4'h0, 1'b0, 16'd2);
    step();
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 5'd10, 5'd0, 2'b01);
    checkAll("flush.after", 4'h2, 1'b0, 16'd2);
    step();

    // No valid instruction in ID: no stall even with a hazard.
    applyStimulus(1'b1, 1'b1, 5'd11, 2'd2, 1'b0, 5'd0, 5'd0, 2'b00);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 2'd1, 1'b0, 5'd11, 5'd0, 2'b01);
    checkAll("noValid", 4'h0, 1'b0, 16'd2);
    step();
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 5'd11, 5'd0, 2'b01);
    checkAll("noValid.after", 4'h2, 1'b0, 16'd2);
    step();

    // Reset mid-operation clears in-flight writes and the counter at once.
    applyStimulus(1'b1, 1'b1, 5'd14, 2'd1, 1'b0, 5'd0, 5'd0, 2'b00);
    step();
    applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 5'd14, 5'd0, 2'b01);
    checkAll("preRst", 4'h1, 1'b0, 16'd2);
    rst_n = 1'b0;
    #1;
    checkAll("midRst", 4'h0, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkAll("afterRst", 4'h0, 1'b0, 16'd0);
    step();

    // Deep instance: a latency-15 load that also reads its own destination
    // gives 14 stall cycles out of every 15 with constant inputs.
    checkOutput("deep.start", deepCount, 16'd0);
    deepValid = 1'b1;
    deepWen   = 1'b1;
    deepDst   = 5'd9;
    deepLat   = 4'd15;
    deepSrc   = {5'd0, 5'd9};
    deepUsed  = 2'b01;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("deep.round1.count", deepCount, 16'd14);
    checkOutput("deep.round1.stall", 16'(deepStall), 16'd0);
    checkOutput("deep.round1.fwd", 16'(deepFwd), 16'h000F);
    repeat (15 * 3999) @(posedge clk);
    #1;
    checkOutput("deep.count56000", deepCount, 16'd56000);
    repeat (15 * 700) @(posedge clk);
    #1;
    checkOutput("deep.saturated", deepCount, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
